// File: rtl/axi_bus_arb2_if.sv
// One port of the two-master arbiter: address, write-data and read-response
// channels with matching master/slave views.
interface axi_bus_arb2_if #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) ();
  logic [ID_W-1:0]     aid;
  logic [ADDR_W-1:0]   aaddr;
  logic [3:0]          alen;
  logic [1:0]          asize;
  logic [1:0]          aburst;
  logic                awrite;
  logic                avalid;
  logic                aready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output aid, aaddr, alen, asize, aburst,
    output awrite, avalid,
    input  aready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );

  modport slave (
    input  aid, aaddr, alen, asize, aburst,
    input  awrite, avalid,
    output aready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_bus_arb2.sv
// Two-master to one-slave bus arbiter: round-robin address grant,
// write data locked to the granted master, reads routed by ID MSB.
module axi_bus_arb2 #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  axi_bus_arb2_if.slave  m0,
  axi_bus_arb2_if.slave  m1,
  axi_bus_arb2_if.master s,
  output logic           busy,
  output logic           wlast_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;

  logic [1:0] st_q, st_d;
  logic       grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] len_q, len_d;
  logic       werr_q, werr_d;
  logic       busy_q;

  logic in_addr;
  logic in_wdata;
  logic a_hs;
  logic w_hs;
  logic r_sel;

  logic [ID_W-1:0]     g_aid;
  logic [ADDR_W-1:0]   g_aaddr;
  logic [3:0]          g_alen;
  logic [1:0]          g_asize;
  logic [1:0]          g_aburst;
  logic                g_awrite;
  logic                g_avalid;
  logic [ID_W-1:0]     g_wid;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;
  logic                g_wlast;
  logic                g_wvalid;

  assign in_addr  = (st_q == ADDR);
  assign in_wdata = (st_q == WDATA);

  assign g_aid    = grant_q ? m1.aid    : m0.aid;
  assign g_aaddr  = grant_q ? m1.aaddr  : m0.aaddr;
  assign g_alen   = grant_q ? m1.alen   : m0.alen;
  assign g_asize  = grant_q ? m1.asize  : m0.asize;
  assign g_aburst = grant_q ? m1.aburst : m0.aburst;
  assign g_awrite = grant_q ? m1.awrite : m0.awrite;
  assign g_avalid = grant_q ? m1.avalid : m0.avalid;
  assign g_wid    = grant_q ? m1.wid    : m0.wid;
  assign g_wdata  = grant_q ? m1.wdata  : m0.wdata;
  assign g_wstrb  = grant_q ? m1.wstrb  : m0.wstrb;
  assign g_wlast  = grant_q ? m1.wlast  : m0.wlast;
  assign g_wvalid = grant_q ? m1.wvalid : m0.wvalid;

  assign a_hs = in_addr & g_avalid & s.aready;
  assign w_hs = in_wdata & g_wvalid & s.wready;

  // Payloads are forced to zero outside their phase so reset clears them at once
  assign s.avalid = in_addr & g_avalid;
  assign s.aid    = in_addr ? {grant_q, g_aid} : '0;
  assign s.aaddr  = in_addr ? g_aaddr  : '0;
  assign s.alen   = in_addr ? g_alen   : '0;
  assign s.asize  = in_addr ? g_asize  : '0;
  assign s.aburst = in_addr ? g_aburst : '0;
  assign s.awrite = in_addr & g_awrite;

  assign s.wvalid = in_wdata & g_wvalid;
  assign s.wid    = in_wdata ? {grant_q, g_wid} : '0;
  assign s.wdata  = in_wdata ? g_wdata : '0;
  assign s.wstrb  = in_wdata ? g_wstrb : '0;
  assign s.wlast  = in_wdata & g_wlast;

  assign m0.aready = in_addr & ~grant_q & s.aready;
  assign m1.aready = in_addr &  grant_q & s.aready;
  assign m0.wready = in_wdata & ~grant_q & s.wready;
  assign m1.wready = in_wdata &  grant_q & s.wready;

  // Read responses bypass the FSM entirely
  assign r_sel     = s.rid[ID_W];
  assign m0.rvalid = s.rvalid & ~r_sel;
  assign m1.rvalid = s.rvalid &  r_sel;
  assign m0.rid    = s.rid[ID_W-1:0];
  assign m1.rid    = s.rid[ID_W-1:0];
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;
  assign m0.rlast  = s.rlast;
  assign m1.rlast  = s.rlast;
  assign s.rready  = r_sel ? m1.rready : m0.rready;

  always_comb begin
    st_d       = st_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    werr_d     = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (m0.avalid | m1.avalid) begin
          grant_d = (m0.avalid & m1.avalid) ? ~rr_last_q : m1.avalid;
          st_d    = ADDR;
        end
      end
      ADDR: begin
        if (a_hs) begin
          rr_last_d  = grant_q;
          len_d      = g_alen;
          beat_cnt_d = '0;
          st_d       = g_awrite ? WDATA : IDLE;
        end
      end
      WDATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          werr_d = g_wlast ? (beat_cnt_q != len_q)
                           : (beat_cnt_q == len_q);
          if (g_wlast) st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= IDLE;
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      beat_cnt_q <= '0;
      len_q      <= '0;
      werr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      werr_q     <= werr_d;
      busy_q     <= (st_d != IDLE);
    end
  end

  assign busy      = busy_q;
  assign wlast_err = werr_q;

endmodule

// File: tb/tb_axi_bus_arb2.sv
// Directed and randomized bench for axi_bus_arb2 with a transaction-level
// model of round-robin order, payload routing and read steering.
module tb_axi_bus_arb2;
  localparam int ID_W   = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  logic wlast_err;
  int   n_chk  = 0;
  int   n_fail = 0;

  axi_bus_arb2_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  axi_bus_arb2_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  axi_bus_arb2_if #(.ID_W(ID_W+1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  axi_bus_arb2 #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .busy      (busy),
    .wlast_err (wlast_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  size;
    logic [1:0]  burst;
    logic        wr;
    logic [31:0] seed;
  } tx_t;

  tx_t  tx [2][16];
  tx_t  t;
  int   nt [2];
  int   idx [2];
  int   beat [2];
  bit   adone [2];
  bit   ahs [2];
  bit   whs [2];
  int   last_src, exp_src, w_src, w_idx, w_k;
  int   n_a, n_w, exp_w, cycles, beats;
  logic [5:0]  r_rid;
  logic        r_v, r_last, r_sel, rr0, rr1;
  logic [63:0] r_data;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bdata(input logic [31:0] seed,
                                        input int k);
    return {seed ^ (32'(k) * 32'd977), ~seed + 32'(k)};
  endfunction

  task automatic drive_a(input int m, input logic [4:0] id,
                         input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] sz, input logic [1:0] bu,
                         input logic wr, input logic v);
    if (m == 0) begin
      m0_if.aid = id; m0_if.aaddr = addr; m0_if.alen = len;
      m0_if.asize = sz; m0_if.aburst = bu;
      m0_if.awrite = wr; m0_if.avalid = v;
    end else begin
      m1_if.aid = id; m1_if.aaddr = addr; m1_if.alen = len;
      m1_if.asize = sz; m1_if.aburst = bu;
      m1_if.awrite = wr; m1_if.avalid = v;
    end
  endtask

  task automatic drive_w(input int m, input logic [4:0] id,
                         input logic [63:0] d, input logic last,
                         input logic v);
    if (m == 0) begin
      m0_if.wid = id; m0_if.wdata = d; m0_if.wstrb = d[7:0];
      m0_if.wlast = last; m0_if.wvalid = v;
    end else begin
      m1_if.wid = id; m1_if.wdata = d; m1_if.wstrb = d[7:0];
      m1_if.wlast = last; m1_if.wvalid = v;
    end
  endtask

  task automatic idle_all();
    drive_a(0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    drive_a(1, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    drive_w(0, '0, '0, 1'b0, 1'b0);
    drive_w(1, '0, '0, 1'b0, 1'b0);
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.aready = 1'b0; s_if.wready = 1'b0;
    s_if.rid = '0; s_if.rdata = '0;
    s_if.rlast = 1'b0; s_if.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_all();
    m0_if.avalid = 1'b1; m1_if.avalid = 1'b1;
    m0_if.wvalid = 1'b1; m1_if.wvalid = 1'b1;
    s_if.aready = 1'b1; s_if.wready = 1'b1;
    #1;
    chk("rst_savalid", s_if.avalid, 0);
    chk("rst_swvalid", s_if.wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_werr", wlast_err, 0);
    chk("rst_m0_aready", m0_if.aready, 0);
    chk("rst_m1_aready", m1_if.aready, 0);
    chk("rst_m0_wready", m0_if.wready, 0);
    chk("rst_m1_wready", m1_if.wready, 0);
    chk("rst_said", s_if.aid, 0);
    chk("rst_saddr", s_if.aaddr, 0);
    @(negedge clk);
    idle_all();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    do_reset();

    // T1: single m0 read, slave stalls two cycles
    @(negedge clk);
    drive_a(0, 5'd5, 32'h1000, 4'd3, 2'd3, 2'd1, 1'b0, 1'b1);
    #1;
    chk("t1_no_comb_path", s_if.avalid, 0);
    chk("t1_busy0", busy, 0);
    @(negedge clk); #1;
    chk("t1_savalid", s_if.avalid, 1);
    chk("t1_said", s_if.aid, 6'h05);
    chk("t1_salen", s_if.alen, 3);
    chk("t1_saddr", s_if.aaddr, 32'h1000);
    chk("t1_aready_wait", m0_if.aready, 0);
    chk("t1_busy1", busy, 1);
    @(negedge clk); #1;
    chk("t1_savalid_hold", s_if.avalid, 1);
    @(negedge clk);
    s_if.aready = 1'b1;
    #1;
    chk("t1_m0_aready", m0_if.aready, 1);
    chk("t1_m1_aready", m1_if.aready, 0);
    @(negedge clk);
    m0_if.avalid = 1'b0;
    #1;
    chk("t1_aready_pulse", m0_if.aready, 0);
    chk("t1_busy_drop", busy, 0);
    chk("t1_idle_savalid", s_if.avalid, 0);

    // T2: simultaneous requests alternate
    do_reset();
    @(negedge clk);
    drive_a(0, 5'd1, 32'h2000, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    drive_a(1, 5'd2, 32'h3000, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    s_if.aready = 1'b1;
    #1;
    chk("t2_idle", s_if.avalid, 0);
    @(negedge clk); #1;
    chk("t2_first_aid", s_if.aid, 6'h01);
    chk("t2_first_m0rdy", m0_if.aready, 1);
    chk("t2_first_m1rdy", m1_if.aready, 0);
    @(negedge clk);
    drive_a(0, 5'd3, 32'h2100, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    #1;
    @(negedge clk); #1;
    chk("t2_second_aid", s_if.aid, 6'h22);
    chk("t2_second_m1rdy", m1_if.aready, 1);
    chk("t2_second_saddr", s_if.aaddr, 32'h3000);
    @(negedge clk);
    drive_a(1, 5'd4, 32'h3100, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    #1;
    @(negedge clk); #1;
    chk("t2_third_aid", s_if.aid, 6'h03);
    chk("t2_third_m0rdy", m0_if.aready, 1);
    @(negedge clk);
    m0_if.avalid = 1'b0; m1_if.avalid = 1'b0;

    // T3: m1 write burst, slave wready toggling, m0 held off
    @(negedge clk);
    drive_a(1, 5'd7, 32'h4000, 4'd3, 2'd3, 2'd1, 1'b1, 1'b1);
    #1;
    @(negedge clk); #1;
    chk("t3_awrite", s_if.awrite, 1);
    chk("t3_aid", s_if.aid, 6'h27);
    @(negedge clk);
    m1_if.avalid = 1'b0;
    drive_a(0, 5'd6, 32'h5000, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    beats = 0;
    for (int c = 0; c < 12 && beats < 4; c++) begin
      if (c > 0) @(negedge clk);
      s_if.wready = (c % 2 == 0);
      drive_w(1, 5'd7, bdata(32'h77, beats), beats == 3, 1'b1);
      #1;
      chk("t3_m0_held", m0_if.aready, 0);
      chk("t3_savalid_off", s_if.avalid, 0);
      chk("t3_werr", wlast_err, 0);
      chk("t3_m1_wready", m1_if.wready, s_if.wready);
      if (s_if.wvalid && s_if.wready) begin
        chk("t3_wid", s_if.wid, 6'h27);
        chk("t3_wdata", s_if.wdata, bdata(32'h77, beats));
        beats++;
      end
    end
    chk("t3_beats", beats, 4);
    @(negedge clk);
    drive_w(1, '0, '0, 1'b0, 1'b0);
    #1;
    chk("t3_wvalid_off", s_if.wvalid, 0);
    chk("t3_busy_idle", busy, 0);
    chk("t3_werr_end", wlast_err, 0);
    @(negedge clk); #1;
    chk("t3_m0_granted", s_if.aid, 6'h06);
    chk("t3_m0_avalid", s_if.avalid, 1);
    @(negedge clk);
    m0_if.avalid = 1'b0;

    // T4: early wlast on second of four beats
    @(negedge clk);
    drive_a(0, 5'd2, 32'h6000, 4'd3, 2'd3, 2'd1, 1'b1, 1'b1);
    #1;
    @(negedge clk); #1;
    chk("t4_savalid", s_if.avalid, 1);
    @(negedge clk);
    m0_if.avalid = 1'b0;
    s_if.wready = 1'b1;
    drive_w(0, 5'd2, bdata(32'h44, 0), 1'b0, 1'b1);
    #1;
    chk("t4_m0_wready", m0_if.wready, 1);
    chk("t4_werr0", wlast_err, 0);
    @(negedge clk);
    drive_w(0, 5'd2, bdata(32'h44, 1), 1'b1, 1'b1);
    #1;
    chk("t4_werr_b1", wlast_err, 0);
    chk("t4_swlast", s_if.wlast, 1);
    @(negedge clk);
    drive_w(0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("t4_werr_pulse", wlast_err, 1);
    chk("t4_busy_idle", busy, 0);
    chk("t4_wvalid_off", s_if.wvalid, 0);
    @(negedge clk); #1;
    chk("t4_werr_clear", wlast_err, 0);

    // T5: read steering during a write burst, plus missing wlast
    @(negedge clk);
    drive_a(0, 5'd4, 32'h7000, 4'd1, 2'd3, 2'd1, 1'b1, 1'b1);
    s_if.wready = 1'b0;
    #1;
    @(negedge clk); #1;
    @(negedge clk);
    m0_if.avalid = 1'b0;
    drive_w(0, 5'd4, bdata(32'h55, 0), 1'b0, 1'b1);
    s_if.rid = 6'h23; s_if.rvalid = 1'b1;
    s_if.rdata = 64'hdead_beef_0123_4567; s_if.rlast = 1'b1;
    m0_if.rready = 1'b1; m1_if.rready = 1'b0;
    #1;
    chk("t5_m1_rvalid", m1_if.rvalid, 1);
    chk("t5_m1_rid", m1_if.rid, 3);
    chk("t5_m0_rvalid", m0_if.rvalid, 0);
    chk("t5_s_rready0", s_if.rready, 0);
    chk("t5_m0_rdata", m0_if.rdata, 64'hdead_beef_0123_4567);
    chk("t5_m0_rid", m0_if.rid, 3);
    chk("t5_m0_rlast", m0_if.rlast, 1);
    chk("t5_in_wdata", s_if.wvalid, 1);
    chk("t5_m0_wready0", m0_if.wready, 0);
    @(negedge clk);
    m1_if.rready = 1'b1;
    #1;
    chk("t5_s_rready1", s_if.rready, 1);
    @(negedge clk);
    s_if.rid = 6'h05; m1_if.rready = 1'b0;
    #1;
    chk("t5_m0_rv_sel", m0_if.rvalid, 1);
    chk("t5_m1_rv_sel", m1_if.rvalid, 0);
    chk("t5_s_rready_m0", s_if.rready, 1);
    @(negedge clk);
    s_if.rvalid = 1'b0; s_if.wready = 1'b1;
    #1;
    chk("t5_werr_b0", wlast_err, 0);
    @(negedge clk);
    drive_w(0, 5'd4, bdata(32'h55, 1), 1'b0, 1'b1);
    #1;
    chk("t5_werr_b0_ok", wlast_err, 0);
    @(negedge clk);
    drive_w(0, 5'd4, bdata(32'h55, 2), 1'b1, 1'b1);
    #1;
    chk("t5_werr_nolast", wlast_err, 1);
    chk("t5_still_fwd", s_if.wvalid, 1);
    @(negedge clk);
    drive_w(0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("t5_werr_latelast", wlast_err, 1);
    chk("t5_busy_idle", busy, 0);
    @(negedge clk); #1;
    chk("t5_werr_clear", wlast_err, 0);

    // T6: async reset in the middle of a write burst
    @(negedge clk);
    drive_a(0, 5'd1, 32'h8000, 4'd3, 2'd3, 2'd1, 1'b1, 1'b1);
    s_if.aready = 1'b1;
    #1;
    @(negedge clk); #1;
    @(negedge clk);
    m0_if.avalid = 1'b0;
    drive_w(0, 5'd1, bdata(32'h66, 0), 1'b0, 1'b1);
    #1;
    @(negedge clk);
    drive_w(0, 5'd1, bdata(32'h66, 1), 1'b0, 1'b1);
    #1;
    @(negedge clk);
    drive_w(0, 5'd1, bdata(32'h66, 2), 1'b0, 1'b1);
    #1;
    chk("t6_wvalid_pre", s_if.wvalid, 1);
    chk("t6_busy_pre", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_wvalid_async", s_if.wvalid, 0);
    chk("t6_avalid_async", s_if.avalid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_wready_async", m0_if.wready, 0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    reset_n = 1'b1;
    drive_a(1, 5'd9, 32'h9000, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1);
    s_if.aready = 1'b1;
    #1;
    chk("t6_idle_after", s_if.avalid, 0);
    @(negedge clk); #1;
    chk("t6_new_aid", s_if.aid, 6'h29);
    chk("t6_new_m1rdy", m1_if.aready, 1);
    chk("t6_new_read", s_if.awrite, 0);
    @(negedge clk);
    idle_all();

    // Random phase: each master issues its own queue one at a time
    do_reset();
    exp_w = 0;
    for (int m = 0; m < 2; m++) begin
      nt[m] = $urandom_range(6, 10);
      idx[m] = 0; beat[m] = 0; adone[m] = 0; ahs[m] = 0; whs[m] = 0;
      for (int i = 0; i < nt[m]; i++) begin
        tx[m][i].id    = 5'($urandom);
        tx[m][i].addr  = $urandom;
        tx[m][i].len   = 4'($urandom_range(0, 5));
        tx[m][i].size  = 2'($urandom);
        tx[m][i].burst = 2'($urandom);
        tx[m][i].wr    = 1'($urandom);
        tx[m][i].seed  = $urandom;
        if (tx[m][i].wr) exp_w += int'(tx[m][i].len) + 1;
      end
    end
    last_src = 1; w_src = 0; w_idx = 0; w_k = 0;
    n_a = 0; n_w = 0; cycles = 0;
    while ((idx[0] < nt[0] || idx[1] < nt[1]) && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      for (int m = 0; m < 2; m++) begin
        if (ahs[m]) adone[m] = 1;
        if (whs[m]) beat[m]++;
        if (idx[m] < nt[m] && adone[m] &&
            (!tx[m][idx[m]].wr || beat[m] > int'(tx[m][idx[m]].len))) begin
          idx[m]++; adone[m] = 0; beat[m] = 0;
        end
        if (idx[m] < nt[m]) begin
          t = tx[m][idx[m]];
          drive_a(m, t.id, t.addr, t.len, t.size, t.burst, t.wr, !adone[m]);
          drive_w(m, t.id, bdata(t.seed, beat[m]),
                  beat[m] == int'(t.len),
                  t.wr && beat[m] <= int'(t.len) && $urandom_range(0, 3) != 0);
        end else begin
          drive_a(m, '0, '0, '0, '0, '0, 1'b0, 1'b0);
          drive_w(m, '0, '0, 1'b0, 1'b0);
        end
      end
      s_if.aready = ($urandom_range(0, 2) != 0);
      s_if.wready = ($urandom_range(0, 2) != 0);
      r_rid = 6'($urandom); r_v = 1'($urandom);
      r_data = {$urandom, $urandom}; r_last = 1'($urandom);
      rr0 = 1'($urandom); rr1 = 1'($urandom);
      s_if.rid = r_rid; s_if.rvalid = r_v;
      s_if.rdata = r_data; s_if.rlast = r_last;
      m0_if.rready = rr0; m1_if.rready = rr1;
      #1;
      r_sel = r_rid[5];
      chk("rd_m0_rvalid", m0_if.rvalid, r_v && !r_sel);
      chk("rd_m1_rvalid", m1_if.rvalid, r_v && r_sel);
      chk("rd_m1_rid", m1_if.rid, r_rid[4:0]);
      chk("rd_m0_rdata", m0_if.rdata, r_data);
      chk("rd_s_rready", s_if.rready, r_sel ? rr1 : rr0);
      chk("rnd_werr", wlast_err, 0);
      chk("rnd_excl_a", m0_if.aready & m1_if.aready, 0);
      chk("rnd_excl_w", m0_if.wready & m1_if.wready, 0);
      if (s_if.avalid && s_if.aready) begin
        if (idx[0] < nt[0] && idx[1] < nt[1]) exp_src = 1 - last_src;
        else exp_src = (idx[0] < nt[0]) ? 0 : 1;
        t = tx[exp_src][idx[exp_src]];
        chk("rnd_src", s_if.aid[5], exp_src);
        chk("rnd_aid", s_if.aid, {exp_src[0], t.id});
        chk("rnd_aaddr", s_if.aaddr, t.addr);
        chk("rnd_alen", s_if.alen, t.len);
        chk("rnd_asize", s_if.asize, t.size);
        chk("rnd_aburst", s_if.aburst, t.burst);
        chk("rnd_awrite", s_if.awrite, t.wr);
        last_src = exp_src;
        if (t.wr) begin
          w_src = exp_src; w_idx = idx[exp_src]; w_k = 0;
        end
        n_a++;
      end
      if (s_if.wvalid && s_if.wready) begin
        t = tx[w_src][w_idx];
        chk("rnd_wid", s_if.wid, {w_src[0], t.id});
        chk("rnd_wdata", s_if.wdata, bdata(t.seed, w_k));
        chk("rnd_wstrb", s_if.wstrb, bdata(t.seed, w_k) & 64'hff);
        chk("rnd_wlast", s_if.wlast, w_k == int'(t.len));
        w_k++;
        n_w++;
      end
      ahs[0] = m0_if.avalid && m0_if.aready;
      ahs[1] = m1_if.avalid && m1_if.aready;
      whs[0] = m0_if.wvalid && m0_if.wready;
      whs[1] = m1_if.wvalid && m1_if.wready;
    end
    chk("rnd_no_timeout", cycles < 5000, 1);
    chk("rnd_addr_count", n_a, nt[0] + nt[1]);
    chk("rnd_beat_count", n_w, exp_w);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
